// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  // One writeback source's request
  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } RfWbReq;

  // Write fields of the register-file input bundle
  typedef struct packed {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } RfWritePort;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: generic round-robin arbiter.
// The search starts one past the last winner. The pointer moves only when a
// grant is issued. After reset the pointer is N-1, so index 0 is searched first.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_cand;
  logic          w_any;

  // first requester at or after r_ptr+1, wrapping modulo N
  always_comb begin
    o_gnt  = '0;
    w_idx  = r_ptr;
    w_cand = r_ptr;
    w_any  = 1'b0;
    for (int off = 1; off <= N; off++) begin
      w_cand = PW'((int'(r_ptr) + off) % N);
      if (!w_any && i_req[w_cand]) begin
        w_any = 1'b1;
        w_idx = w_cand;
      end
    end
    if (w_any) o_gnt[w_idx] = 1'b1;
  end

  // remember the last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= PW'(N - 1);
    else if (w_any) r_ptr <= w_idx;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among NUM_SRC
// writeback sources with round-robin arbitration and a 1-cycle registered write.
// Optional macro RF_WB_SCOREBOARD_EN adds a per-register pending-write
// scoreboard that drives iss_ready and rs1_busy/rs2_busy. Without the macro,
// iss_ready is tied to 1 and both busy outputs are tied to 0.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = rf_wb_arbiter_pkg::XLEN,
  parameter int AW      = rf_wb_arbiter_pkg::AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [NUM_SRC*AW-1:0]   src_waddr,
  input  logic [NUM_SRC*XLEN-1:0] src_wdata,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic                    rf_we,
  output logic [AW-1:0]           rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  output logic                    iss_ready,
  input  logic [AW-1:0]           rs1_addr,
  input  logic [AW-1:0]           rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy
);

  RfWbReq     w_req [NUM_SRC];
  RfWbReq     w_sel;
  RfWritePort r_wp;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_req
    assign w_req[g] = '{valid: src_valid[g],
                        waddr: src_waddr[g*AW +: AW],
                        wdata: src_wdata[g*XLEN +: XLEN]};
  end

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .i_req (src_valid),
    .o_gnt (src_ready)
  );

  // one-hot grant mux; w_sel.valid is high only when some source is granted
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_ready[i]) w_sel = w_req[i];
  end

  // write stage: register the winner; writes to x0 are accepted but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_wp <= '0;
    else if (w_sel.valid) r_wp <= '{we: (w_sel.waddr != '0), waddr: w_sel.waddr, wdata: w_sel.wdata};
    else                  r_wp.we <= 1'b0;
  end

  assign rf_we    = r_wp.we;
  assign rf_waddr = r_wp.waddr;
  assign rf_wdata = r_wp.wdata;

`ifdef RF_WB_SCOREBOARD_EN
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_iss_fire;

  // A write landing this cycle frees its register. The register file forwards
  // that write to readers, so neither issue nor operand reads need to stall.
  assign iss_ready  = !(r_busy[iss_rd] && !(rf_we && rf_waddr == iss_rd));
  assign w_iss_fire = iss_valid && iss_ready && (iss_rd != '0);
  assign rs1_busy   = (rs1_addr != '0) && r_busy[rs1_addr] && !(rf_we && rf_waddr == rs1_addr);
  assign rs2_busy   = (rs2_addr != '0) && r_busy[rs2_addr] && !(rf_we && rf_waddr == rs2_addr);

  // Clear first, then set: a new writer issued in the same cycle stays outstanding
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf_we)      w_busy_nxt[rf_waddr] = 1'b0;
    if (w_iss_fire) w_busy_nxt[iss_rd]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end
`else
  logic w_unused;
  assign w_unused  = ^{iss_valid, iss_rd, rs1_addr, rs2_addr};
  assign iss_ready = 1'b1;
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule
